// File: rtl/if_fetch_unit_if.sv
// Bus bundle for the instruction-fetch unit: arbiter IF port plus the decode handshake.
// The fetch unit is the master; the arbiter/decode environment is the slave.
interface if_fetch_unit_if;
    logic       req_if;
    logic       if_read;
    logic [7:0] if_addr;
    logic       granted_to_if;
    logic       stall_if;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;

    modport master (
        output req_if, if_read, if_addr, instr_valid, instr, instr_pc,
        input  granted_to_if, stall_if, mem_rdata, instr_ready
    );

    modport slave (
        input  req_if, if_read, if_addr, instr_valid, instr, instr_pc,
        output granted_to_if, stall_if, mem_rdata, instr_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches through the arbiter, buffers bytes for decode.
// Optional macro IF_PERF_CNT_EN adds a saturating stall_cycles counter output.
module if_fetch_unit #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           redirect_valid,
    input  logic [7:0]     redirect_pc,
    if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]    stall_cycles
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_FULL, ST_REDIRECT} state_e;

    state_e        state_q, state_d;
    logic [7:0]    pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [7:0]    inflight_addr_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    addr_mem [DEPTH];
    logic [7:0]    data_mem [DEPTH];

    logic req, grant, push, pop, drop, head_valid;

    // count+inflight is the number of slots already promised; never request past DEPTH.
    assign req        = reset && (state_q == ST_RUN) && ((count_q + CW'(inflight_q)) < DEPTH_C);
    assign grant      = req && bus.granted_to_if && !bus.stall_if;
    assign drop       = redirect_valid;
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && bus.instr_ready && !drop;
    assign push       = inflight_q && !drop;

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        inflight_d = grant;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (drop) begin
            // Clearing inflight here discards the return of a grant made this cycle.
            pc_d       = redirect_pc;
            count_d    = '0;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 8'd1;
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if ((count_d + CW'(inflight_d)) == DEPTH_C) state_d = ST_FULL;
            ST_FULL:     if ((count_d + CW'(inflight_d)) < DEPTH_C) state_d = ST_RUN;
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
        if (redirect_valid) begin
            state_d = ST_REDIRECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_PC;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 8'h00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (grant) begin
                inflight_addr_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            addr_mem[wr_ptr_q] <= inflight_addr_q;
            data_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.req_if      = req;
    assign bus.if_read     = req;
    assign bus.if_addr     = req ? pc_q : 8'h00;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? data_mem[rd_ptr_q] : 8'h00;
    assign bus.instr_pc    = head_valid ? addr_mem[rd_ptr_q] : 8'h00;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_q == DEPTH_C)));

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= 16'h0000;
        end else if (req && (bus.stall_if || !bus.granted_to_if) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the memory arbiter.
- Owns the PC and issues fetch requests on the arbiter's IF port (req_if, if_read, if_addr).
- Honours granted_to_if and stall_if, and captures returned bytes into a small prefetch queue.
- Presents instructions to decode with a valid/ready handshake; supports branch redirect with flush.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, minimum 2.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- redirect_valid  input  1  branch/jump redirect request from execute
- redirect_pc  input  8  redirect target address
- req_if  output  1  fetch request to arbiter
- if_read  output  1  read qualifier to arbiter; equals req_if
- if_addr  output  8  fetch address to arbiter
- granted_to_if  input  1  arbiter granted memory to IF this cycle
- stall_if  input  1  arbiter stall (memory owned by MEM stage)
- mem_rdata  input  8  memory read data, valid one cycle after grant
- instr_valid  output  1  queue head holds a valid instruction byte
- instr  output  8  queue head instruction byte
- instr_pc  output  8  address of queue head byte
- instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (reset==0 at clk edge):
  - pc=RESET_PC; queue count=0; inflight=0; state=RUN.
  - req_if=0, if_read=0, if_addr=0, instr_valid=0, instr=0, instr_pc=0.
- Memory timing:
  - A grant is req_if && granted_to_if && !stall_if in cycle N.
  - mem_rdata for that grant is sampled in cycle N+1.
  - The inflight flag is set in N and cleared in N+1 unless a new grant occurs in N+1.
  - Back-to-back grants are allowed (one fetch per cycle peak).
- Request rule: req_if=1 when state==RUN and count+inflight < DEPTH.
  - if_addr=pc.
  - A request not granted is held with an unchanged address until granted.
- PC increment: pc+1 on each grant, 8-bit wrap (8'hFF -> 8'h00).
- Queue:
  - Each entry holds {addr, byte}; captured address is the granted address.
  - Push occurs on data return; pop occurs on instr_valid && instr_ready.
  - Push and pop in the same cycle are legal at any count.
  - Overflow is impossible by the request rule; overflow checking is an assertion only.
- FSM states:
  - RUN: normal fetching. Goes to FULL when count+inflight (next) == DEPTH. Goes to REDIRECT on redirect_valid.
  - FULL: req_if=0. Goes to RUN when a pop frees space. Goes to REDIRECT on redirect_valid.
  - REDIRECT: one-cycle bubble with req_if=0. Queue is empty and inflight data is discarded. Goes to RUN next cycle.
- Redirect (redirect_valid=1 at edge, any state):
  - pc<=redirect_pc and count<=0.
  - instr_valid=0 the next cycle.
  - A pop in the same cycle is ignored.
  - A grant issued in the same cycle has its return data dropped via a drop flag.
  - Data returning in the same cycle as the redirect is dropped.
  - First new request appears 2 cycles after the redirect edge.
- stall_if=1 overrides granted_to_if: no grant, PC and inflight unchanged, queue still drains to decode.
- Reset asserted mid-operation overrides redirect, grant and pop; any pending return data is discarded.
- instr and instr_pc are driven from queue head registers with no combinational path from mem_rdata.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined:
  - Adds output stall_cycles[15:0], reset to 0.
  - Increments each cycle req_if && (stall_if || !granted_to_if).
  - Saturates at 16'hFFFF.
  - Cleared on redirect? No — counts across redirects; only reset clears it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=8'h10, granted_to_if=1, mem_rdata=addr^8'hA5, instr_ready=1 -> if_addr sequence 10,11,12...; instr/instr_pc pairs (B5,10),(B4,11)... one per cycle after 2-cycle startup.
- instr_ready=0, DEPTH=4 -> exactly 4 grants occur, req_if drops, state FULL; raise ready for 1 cycle -> one pop, one new request next cycle.
- stall_if=1 for 5 cycles while req_if=1 at if_addr=8'h22 -> if_addr holds 22, no push; stall_if deasserts -> byte for 22 enqueued next cycle (stall_cycles=5 with IF_PERF_CNT_EN).
- redirect_valid with redirect_pc=8'h80 in the same cycle as a grant and a data return -> both bytes dropped, instr_valid=0 for 2 cycles, first fetch at 80, first instr_pc=80.
- PC at 8'hFE with continuous grants -> addresses FE,FF,00,01 with matching instr_pc; no spurious bytes.
- Assert reset (0) while queue holds 3 entries and one read is in flight -> next cycle instr_valid=0, req_if=0; after release, first fetch at RESET_PC and in-flight data is not enqueued.
